// File: rtl/mmio_arb_pkg.sv
// rtl/mmio_arb_pkg.sv - shared types and constants for the MMIO arbiter
// Contents: owner state encoding, master index constants, default idle address.
package mmio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    LOCK1 = 2'd3
  } owner_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Top of the address space, outside every decoded mmio register.
  localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFC;

endpackage

// File: rtl/mmio_arb_rr_pick.sv
// rtl/mmio_arb_rr_pick.sv - two-way round-robin picker
// Ports:
//   req      in  2  request per master (bit index = master index)
//   last_gnt in  1  master granted most recently
//   force0   in  1  give M0 priority this cycle (end of an M1 lock)
//   gnt      out 2  one-hot grant, never set without the matching req
module mmio_arb_rr_pick
  import mmio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       force0,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (force0 && req[M0]) begin
      gnt = 2'b01;
    end else if (req == 2'b11) begin
      // Tie: the master that did not win last time goes now.
      gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - round-robin share of the single-cycle mmio slave port
// Optional feature macro: MMIO_ARB_LOCK_EN (M1 bus lock with MAX_LOCK bound).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   m0_* / m1_*              req, addr, wmask (0 = read), wdata in;
//                            gnt (combinational), rvalid, rdata (registered) out
//   m1_lock                  M1 lock request (ignored without the macro)
//   mmio_o_addr/wmask/wdata  request towards the mmio block
//   mmio_i_rdata             read data from the mmio block
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR = DEFAULT_IDLE_ADDR,
  parameter int unsigned MAX_LOCK  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wmask,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wmask,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  input  logic        m1_lock,
  output logic [31:0] mmio_o_addr,
  output logic [3:0]  mmio_o_wmask,
  output logic [31:0] mmio_o_wdata,
  input  logic [31:0] mmio_i_rdata
);

  owner_e     state;
  owner_e     state_next;
  logic       last_gnt;
  logic [1:0] req;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic       force0;

  // Holding reset keeps every grant low and the slave port idle.
  assign req = rst ? {m1_req, m0_req} : 2'b00;

`ifdef MMIO_ARB_LOCK_EN
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_next;
  logic       locked;
  logic       lock_cycle;

  // Counter at the limit: this cycle belongs to M0 if it wants it.
  assign force0 = (lock_cnt == MAX_LOCK[7:0]);
  assign locked = rst && (state == LOCK1) && m1_lock && !force0;
`else
  logic [10:0] unused_cfg;
  assign force0     = 1'b0;
  assign unused_cfg = {m1_lock, state, MAX_LOCK[7:0]};
`endif

  mmio_arb_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .force0   (force0),
    .gnt      (pick_gnt)
  );

  always_comb begin
    gnt = pick_gnt;
`ifdef MMIO_ARB_LOCK_EN
    // Under lock M0 is shut out even while M1 is momentarily not requesting.
    if (locked) begin
      gnt = {m1_req, 1'b0};
    end
`endif
  end

  assign m0_gnt = gnt[M0];
  assign m1_gnt = gnt[M1];

  always_comb begin
    mmio_o_addr  = IDLE_ADDR;
    mmio_o_wmask = 4'h0;
    mmio_o_wdata = 32'h0;
    if (gnt[M0]) begin
      mmio_o_addr  = m0_addr;
      mmio_o_wmask = m0_wmask;
      mmio_o_wdata = m0_wdata;
    end else if (gnt[M1]) begin
      mmio_o_addr  = m1_addr;
      mmio_o_wmask = m1_wmask;
      mmio_o_wdata = m1_wdata;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (gnt[M0]) begin
      state_next = OWN0;
    end else if (gnt[M1]) begin
      state_next = OWN1;
    end
`ifdef MMIO_ARB_LOCK_EN
    // A lock cycle is a locked M1 grant, a locked idle cycle, or a fresh
    // lock start; the forced M0 turn restarts the count from this cycle.
    lock_cycle    = (gnt[M1] && m1_lock) || locked;
    lock_cnt_next = 8'd0;
    if (lock_cycle) begin
      state_next    = LOCK1;
      lock_cnt_next = force0 ? 8'd1 : lock_cnt + 8'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= M1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      state     <= state_next;
      m0_rvalid <= gnt[M0];
      m1_rvalid <= gnt[M1];
      if (|gnt) begin
        last_gnt <= gnt[M1];
      end
      if (gnt[M0]) begin
        m0_rdata <= mmio_i_rdata;
      end
      if (gnt[M1]) begin
        m1_rdata <= mmio_i_rdata;
      end
    end
  end

`ifdef MMIO_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt <= 8'd0;
    end else begin
      lock_cnt <= lock_cnt_next;
    end
  end
`endif

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Shares the single-cycle MMIO slave port (addr/wmask/wdata in, rdata out) between two requesters.
- M0 is the CPU load/store unit; M1 is the debug/loader master.
- Round-robin arbitration; one transaction per cycle.
- Read data is registered and returned to the owning master one cycle after grant with an rvalid pulse.
- Sits between the core's data port and the mmio block; the mmio block is unchanged.

Parameters:
- IDLE_ADDR, 32'hFFFF_FFFC, address driven on the slave port when no master is granted; must not decode to any register.
- MAX_LOCK, 16, maximum consecutive cycles M1 may hold the bus under lock (optional feature only); range 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- m0_req  in  1  M0 transaction request
- m0_addr  in  32  M0 byte address
- m0_wmask  in  4  M0 byte write mask; 0 = read
- m0_wdata  in  32  M0 write data
- m0_gnt  out  1  M0 granted this cycle (combinational)
- m0_rvalid  out  1  M0 response valid (registered)
- m0_rdata  out  32  M0 response data
- m1_req, m1_addr, m1_wmask, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as M0, for M1
- m1_lock  in  1  M1 lock request (used only with MMIO_ARB_LOCK_EN)
- mmio_o_addr  out  32  to slave
- mmio_o_wmask  out  4  to slave
- mmio_o_wdata  out  32  to slave
- mmio_i_rdata  in  32  from slave

Behaviour:
- Reset (rst=0 at posedge):
  - owner state = IDLE; m0_rvalid = m1_rvalid = 0; m0_rdata = m1_rdata = 0; last_gnt = M1 (so M0 wins the first tie).
  - While rst=0, both gnt = 0 and the slave port is forced idle.
- Idle slave port: mmio_o_addr = IDLE_ADDR, mmio_o_wmask = 0, mmio_o_wdata = 0.
- Arbitration (combinational, each cycle):
  - Only one req → grant it.
  - Both req → grant the master not equal to last_gnt.
  - No req → no grant.
  - gnt is never asserted without the matching req; at most one gnt is high.
- Granted master's addr/wmask/wdata are muxed onto mmio_o_* in the same cycle.
- Owner FSM: states IDLE, OWN0, OWN1; next state = master granted this cycle, or IDLE if none. last_gnt updates only on a grant.
- Response, registered at the posedge following a grant:
  - Owner's rdata <= mmio_i_rdata, sampled in the grant cycle.
  - Owner's rvalid = 1 for exactly one cycle; the other master's rvalid = 0.
  - Writes also produce rvalid; rdata is then don't-care but still captured.
  - Non-owner rdata holds its previous value.
- Back-to-back: a master holding req continuously with no contention is granted every cycle; rvalid is high every cycle, lagging grant by one cycle.
- Contention with both reqs held: grants alternate M0, M1, M0, ...; no master waits more than 1 cycle.
- A request that is not granted must be held with stable addr/wmask/wdata until gnt; the arbiter does not queue it.
- Reset asserted mid-transaction: the pending rvalid is dropped (0 next cycle) and no response is delivered.

Optional Feature:
- Macro: MMIO_ARB_LOCK_EN
- With the macro:
  - Lock start: m1_lock=1 while M1 is granted starts a lock.
  - During the lock: M1 is granted whenever m1_req=1 regardless of M0; M0 is blocked.
  - Lock counter: 8-bit, increments per locked cycle.
  - Lock end: m1_lock drops, or the counter reaches MAX_LOCK. On reaching MAX_LOCK, the next cycle forces a grant to M0 if m0_req, then the counter clears.
  - Additional FSM state LOCK1; reset clears the lock and the counter.
- Without the macro: m1_lock is ignored; no counter or LOCK1 state; pure round-robin.

Decomposition:
- Package mmio_arb_pkg:
  - owner state encoding (IDLE, OWN0, OWN1, LOCK1)
  - master index constants M0 = 0, M1 = 1
  - default IDLE_ADDR
- Sub-module mmio_arb_rr_pick: 2-way round-robin picker (reqs, last_gnt, force0 → one-hot gnt). Purely combinational; instantiated once.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → gnt=0, rvalid=0, mmio_o_addr=FFFF_FFFC, mmio_o_wmask=0.
- M0 write then read: M0 writes 0x0000_0005 to 0x4, wmask=F → m0_gnt same cycle, m0_rvalid next cycle. M0 then reads 0x4 → m0_rdata = 0x0000_0005 one cycle after grant.
- Contention: both req continuously for 6 cycles, reading 0x0 → grants M0, M1, M0, M1, M0, M1; each rvalid follows its grant by 1 cycle, never overlapping.
- Reset mid-read: M1 granted a read, rst=0 on the next edge → m1_rvalid stays 0; after release, M0 wins the first tie.
- Lock (MMIO_ARB_LOCK_EN, MAX_LOCK=4): M1 lock+req and M0 req held → M1 granted 4 cycles, M0 granted 1 cycle, then M1 lock resumes.
- No macro: same stimulus as the lock test → strict alternation, m1_lock ignored.
